serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Purpose: 32-bit subtractor computing diff = a - b - b_in in eight 4-bit slices, one slice per clock.
// Latency: accept edge E, then done=1 in the cycle after edge E+8 (9 edges per operation).
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk    - core clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - operation request, accepted in IDLE or DONE
//   a, b   - 32-bit minuend / subtrahend, latched on the accepting edge
//   b_in   - borrow-in, latched on the accepting edge
//   diff   - registered result a - b - b_in (mod 2^32)
//   b_out  - registered borrow-out (unsigned a < b + b_in)
//   ovf    - registered two's-complement overflow flag
//   zero   - registered flag, diff == 0
//   busy   - high while slices are being computed
//   done   - one-cycle completion pulse
module serial_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        b_in,
  output logic [31:0] diff,
  output logic        b_out,
  output logic        ovf,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_bn;      // subtrahend stored inverted: a - b = a + ~b + 1
  logic        r_carry;   // running carry; carry-in is ~b_in
  logic [2:0]  r_cnt;
  logic [31:0] r_res;
  logic [31:0] r_diff;
  logic        r_b_out;
  logic        r_ovf;
  logic        r_zero;

  logic [4:0]  w_idx;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [4:0]  w_s;
  logic [31:0] w_res_nxt;

  assign w_idx = {r_cnt, 2'b00};

  always_comb begin
    w_a_nib   = r_a[w_idx +: 4];
    w_b_nib   = r_bn[w_idx +: 4];
    w_s       = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    w_res_nxt = r_res;
    w_res_nxt[w_idx +: 4] = w_s[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_bn    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_bn    <= ~b;
            r_carry <= ~b_in;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_res   <= w_res_nxt;
          r_carry <= w_s[4];
          if (r_cnt == 3'd7) begin
            // Last slice: publish all outputs together so they never show partial results.
            r_state <= ST_DONE;
            r_diff  <= w_res_nxt;
            r_b_out <= ~w_s[4];
            // Operand signs differ (a[31] == ~b[31]) and result sign differs from a.
            r_ovf   <= (r_a[31] == r_bn[31]) && (w_s[3] != r_a[31]);
            r_zero  <= (w_res_nxt == 32'h0);
          end else begin
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign diff  = r_diff;
  assign b_out = r_b_out;
  assign ovf   = r_ovf;
  assign zero  = r_zero;
  assign busy  = (r_state == ST_BUSY);
  assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: self-checking bench for serial_subtractor against an arithmetic reference model.
// Latency: checks done exactly 8 edges after the accepting edge and a 9-cycle back-to-back period.
// Backpressure: exercises ignored start/operand changes while busy and reset mid-operation.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_in;
  logic [31:0] diff;
  logic        b_out;
  logic        ovf;
  logic        zero;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Last completed result, expected to be held on the outputs between completions.
  logic [31:0] prev_diff;
  logic        prev_b_out, prev_ovf, prev_zero;

  serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: 33-bit unsigned subtraction gives the borrow in the top bit.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                       output logic [31:0] md, output logic mbo, output logic mov, output logic mz);
    logic [32:0] full;
    full = {1'b0, ma} - {1'b0, mb} - {32'b0, mbin};
    md   = full[31:0];
    mbo  = full[32];
    mov  = (ma[31] != mb[31]) && (md[31] != ma[31]);
    mz   = (md == 32'h0);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_diff"},  diff,         prev_diff);
    check({tag, "_bout"},  {31'b0, b_out}, {31'b0, prev_b_out});
    check({tag, "_ovf"},   {31'b0, ovf},   {31'b0, prev_ovf});
    check({tag, "_zero"},  {31'b0, zero},  {31'b0, prev_zero});
  endtask

  // One operation: drive at negedge, accept at next posedge, scramble inputs while busy,
  // expect done after exactly 8 more edges. With hold=1 start stays high for back-to-back.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin, input bit hold);
    logic [31:0] ed;
    logic eb, eo, ez;
    model(oa, ob, obin, ed, eb, eo, ez);
    @(negedge clk);
    start = 1'b1; a = oa; b = ob; b_in = obin;
    @(posedge clk); #1;
    check("accept_busy", {31'b0, busy}, 32'd1);
    check("accept_done", {31'b0, done}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; b_in = 1'($urandom);
      start = hold ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      if (i < 8) begin
        if (busy !== 1'b1 || done !== 1'b0)
          check("busy_phase", {30'b0, busy, done}, 32'd2);
        if (i == 4) check_held("hold_mid");
      end else begin
        check("done_pulse", {30'b0, busy, done}, 32'd1);
        check("diff",  diff, ed);
        check("b_out", {31'b0, b_out}, {31'b0, eb});
        check("ovf",   {31'b0, ovf},   {31'b0, eo});
        check("zero",  {31'b0, zero},  {31'b0, ez});
      end
    end
    prev_diff = ed; prev_b_out = eb; prev_ovf = eo; prev_zero = ez;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("idle_after", {30'b0, busy, done}, 32'd0);
      check_held("hold_idle");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_diff"}, diff, 32'h0);
    check({tag, "_flags"}, {26'b0, b_out, ovf, zero, busy, done, 1'b0}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; b_in = 1'b1;
    prev_diff = '0; prev_b_out = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_start_ign");
    start = 1'b0;
    #1 rst_n = 1'b1;

    // Directed cases.
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

    // Randomized operations.
    for (int k = 0; k < 20; k++)
      do_op($urandom, $urandom, 1'($urandom), 1'b0);

    // Back-to-back with start held high: 9-cycle period, each result from its own accept.
    for (int k = 0; k < 6; k++)
      do_op($urandom, (k == 2) ? 32'h0 : $urandom, 1'($urandom), 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", {30'b0, busy, done}, 32'd0);

    // Reset in the middle of an operation (slice 4), with non-zero outputs beforehand.
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 32'h0000_0009; b = 32'h0000_0002; b_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    start = 1'b0;
    prev_diff = '0; prev_b_out = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0);
    do_op($urandom, $urandom, 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
